// File: rtl/flit_to_packet_assembler_pkg.sv
// Shared network defines: flit header/type/VC typedefs and the payload width macro.
// Every flit carries one PAYLOAD_W-bit chunk of the packet body.
`ifndef PAYLOAD_W
`define PAYLOAD_W 64
`endif

package flit_to_packet_assembler_pkg;

   typedef enum logic [1:0] {
      HEADER = 2'd0,
      BODY   = 2'd1,
      TAIL   = 2'd2,
      HT     = 2'd3
   } flit_type_t;

   typedef enum logic [1:0] {
      VC0 = 2'd0,
      VC1 = 2'd1,
      VC2 = 2'd2,
      VC3 = 2'd3
   } vc_id_t;

   typedef struct packed {
      flit_type_t flit_type;
      vc_id_t     vc_id;
   } flit_header_t;

endpackage

// File: rtl/flit_to_packet_assembler.sv
// Reassembles HEADER..TAIL or single HT flits from one virtual channel into a packet body
// held until the consumer takes it; framing violations raise a one-cycle protocol_error.
`ifndef PAYLOAD_W
`define PAYLOAD_W 64
`endif

module flit_to_packet_assembler
   import flit_to_packet_assembler_pkg::*;
#(
   parameter vc_id_t      VCID             = VC0,
   parameter int unsigned PACKET_BODY_SIZE = 256
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic                        flit_valid,
   input  flit_header_t                flit_in_header,
   input  logic [`PAYLOAD_W-1:0]       flit_in_payload,
   output logic                        flit_ready,
   output logic                        packet_valid,
   output logic [PACKET_BODY_SIZE-1:0] packet_body,
   output logic                        packet_has_data,
   input  logic                        packet_consumed,
   output logic                        protocol_error
);

   localparam int unsigned FLIT_NUMB     = (PACKET_BODY_SIZE + `PAYLOAD_W - 1) / `PAYLOAD_W;
   localparam int unsigned COUNTER_WIDTH = $clog2(PACKET_BODY_SIZE);
   localparam int unsigned STORE_W       = FLIT_NUMB * `PAYLOAD_W;
   localparam logic [COUNTER_WIDTH-1:0] LAST_IDX = COUNTER_WIDTH'(FLIT_NUMB - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      READY   = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic [COUNTER_WIDTH-1:0] count_q, count_d;
   logic [STORE_W-1:0]       store_q, store_d;
   logic                     has_data_q, has_data_d;
   logic                     error_q, error_d;
   logic                     accept;
   logic                     start_packet;

   assign flit_ready      = (state_q != READY);
   assign packet_valid    = (state_q == READY);
   assign packet_body     = store_q[PACKET_BODY_SIZE-1:0];
   assign packet_has_data = has_data_q;
   assign protocol_error  = error_q;

   assign accept = flit_valid & flit_ready & enable & (flit_in_header.vc_id == VCID);

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      store_d      = store_q;
      has_data_d   = has_data_q;
      error_d      = 1'b0;
      start_packet = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               if (flit_in_header.flit_type == HEADER || flit_in_header.flit_type == HT)
                  start_packet = 1'b1;
               else
                  error_d = 1'b1;
            end
         end
         COLLECT: begin
            if (accept) begin
               unique case (flit_in_header.flit_type)
                  HEADER, HT: begin
                     error_d      = 1'b1;
                     start_packet = 1'b1;
                  end
                  BODY: begin
                     for (int unsigned i = 0; i < FLIT_NUMB; i++)
                        if (count_q == COUNTER_WIDTH'(i))
                           store_d[i*`PAYLOAD_W +: `PAYLOAD_W] = flit_in_payload;
                     // A BODY landing in the last slot completes the packet but is still a framing fault.
                     if (count_q == LAST_IDX) begin
                        error_d = 1'b1;
                        state_d = READY;
                     end else begin
                        count_d = count_q + COUNTER_WIDTH'(1);
                     end
                  end
                  TAIL: begin
                     if (count_q == LAST_IDX)
                        store_d[FLIT_NUMB*`PAYLOAD_W-1 -: `PAYLOAD_W] = flit_in_payload;
                     else
                        error_d = 1'b1;
                     state_d = READY;
                  end
                  default: ;
               endcase
            end
         end
         READY: begin
            if (packet_consumed) begin
               state_d    = IDLE;
               store_d    = '0;
               count_d    = '0;
               has_data_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      // Shared by IDLE and the COLLECT restart path: a fresh packet discards any partial data.
      if (start_packet) begin
         store_d                  = '0;
         store_d[`PAYLOAD_W-1:0]  = flit_in_payload;
         if (flit_in_header.flit_type == HT) begin
            count_d    = '0;
            has_data_d = 1'b0;
            state_d    = READY;
         end else begin
            count_d    = COUNTER_WIDTH'(1);
            has_data_d = 1'b1;
            state_d    = COLLECT;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         count_q    <= '0;
         store_q    <= '0;
         has_data_q <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         store_q    <= store_d;
         has_data_q <= has_data_d;
         error_q    <= error_d;
      end
   end

endmodule

// File: tb/tb_flit_to_packet_assembler.sv
// Scoreboard bench for flit_to_packet_assembler with 64-bit payloads and a 256-bit body.
`ifndef PAYLOAD_W
`define PAYLOAD_W 64
`endif

module tb_flit_to_packet_assembler;
   import flit_to_packet_assembler_pkg::*;

   typedef struct {
      logic [255:0] body;
      logic         hd;
   } pkt_t;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         enable = 1'b1;
   logic         flit_valid = 1'b0;
   flit_header_t flit_in_header = '{flit_type: HEADER, vc_id: VC0};
   logic [63:0]  flit_in_payload = '0;
   logic         flit_ready;
   logic         packet_valid;
   logic [255:0] packet_body;
   logic         packet_has_data;
   logic         packet_consumed = 1'b0;
   logic         protocol_error;

   int   tests_run = 0;
   int   tests_failed = 0;
   int   err_cnt = 0;
   pkt_t sb[$];

   localparam logic [63:0] PA = 64'hA1A1_0000_0000_00A1;
   localparam logic [63:0] PB = 64'hB2B2_1111_2222_00B2;
   localparam logic [63:0] PC = 64'hC3C3_3333_4444_00C3;
   localparam logic [63:0] PD = 64'hD4D4_5555_6666_00D4;
   localparam logic [63:0] PE = 64'hE5E5_7777_8888_00E5;
   localparam logic [63:0] PX = 64'hDEAD_BEEF_DEAD_BEEF;

   flit_to_packet_assembler #(
      .VCID             (VC0),
      .PACKET_BODY_SIZE (256)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .enable          (enable),
      .flit_valid      (flit_valid),
      .flit_in_header  (flit_in_header),
      .flit_in_payload (flit_in_payload),
      .flit_ready      (flit_ready),
      .packet_valid    (packet_valid),
      .packet_body     (packet_body),
      .packet_has_data (packet_has_data),
      .packet_consumed (packet_consumed),
      .protocol_error  (protocol_error)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (protocol_error === 1'b1) err_cnt++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_flit(input flit_type_t t, input vc_id_t v, input logic [63:0] p, input logic en);
      @(negedge clk);
      flit_valid      = 1'b1;
      flit_in_header  = '{flit_type: t, vc_id: v};
      flit_in_payload = p;
      enable          = en;
   endtask

   task automatic get_packet(output logic [255:0] b, output logic hd, output int lat);
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         flit_valid = 1'b0;
         enable     = 1'b1;
         lat++;
         if (packet_valid === 1'b1) break;
      end
      if (packet_valid !== 1'b1) lat = 99;
      b  = packet_body;
      hd = packet_has_data;
      #1;
   endtask

   task automatic do_consume;
      @(negedge clk);
      flit_valid      = 1'b0;
      packet_consumed = 1'b1;
      @(negedge clk);
      packet_consumed = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      tests_run++;
      if (packet_valid !== 1'b0 || protocol_error !== 1'b0 || packet_has_data !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_ctrl: valid=%b err=%b hd=%b expected 0 0 0", packet_valid, protocol_error, packet_has_data);
      end
      tests_run++;
      if (packet_body !== 256'd0) begin
         tests_failed++;
         $display("FAIL reset_body: got %h expected 0", packet_body);
      end
      tests_run++;
      if (flit_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_ready: got %b expected 1", flit_ready);
      end
      reset = 1'b1;
   endtask

   task automatic test_full_packet;
      pkt_t exp; logic [255:0] b; logic hd; int lat; int e0;
      e0 = err_cnt;
      sb.push_back('{{PD, PC, PB, PA}, 1'b1});
      send_flit(HEADER, VC0, PA, 1'b1);
      send_flit(BODY,   VC0, PB, 1'b1);
      send_flit(BODY,   VC0, PC, 1'b1);
      send_flit(TAIL,   VC0, PD, 1'b1);
      get_packet(b, hd, lat);
      exp = sb.pop_front();
      tests_run++;
      if (lat !== 1) begin tests_failed++; $display("FAIL full_latency: got %0d cycles expected 1", lat); end
      tests_run++;
      if (b !== exp.body || hd !== exp.hd) begin
         tests_failed++;
         $display("FAIL full_body: got %h/%b expected %h/%b", b, hd, exp.body, exp.hd);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests_run++;
         if (flit_ready !== 1'b0 || packet_valid !== 1'b1 || packet_body !== exp.body) begin
            tests_failed++;
            $display("FAIL full_hold: ready=%b valid=%b body=%h expected 0 1 %h", flit_ready, packet_valid, packet_body, exp.body);
         end
      end
      tests_run++;
      if (err_cnt - e0 !== 0) begin tests_failed++; $display("FAIL full_err: got %0d pulses expected 0", err_cnt - e0); end
      do_consume();
      tests_run++;
      if (packet_valid !== 1'b0 || flit_ready !== 1'b1 || packet_body !== 256'd0) begin
         tests_failed++;
         $display("FAIL full_consume: valid=%b ready=%b body=%h expected 0 1 0", packet_valid, flit_ready, packet_body);
      end
   endtask

   task automatic test_ht;
      pkt_t exp; logic [255:0] b; logic hd; int lat; int e0;
      e0 = err_cnt;
      sb.push_back('{{192'd0, 64'h1234}, 1'b0});
      send_flit(HT, VC0, 64'h1234, 1'b1);
      get_packet(b, hd, lat);
      exp = sb.pop_front();
      tests_run++;
      if (lat !== 1 || b !== exp.body || hd !== exp.hd) begin
         tests_failed++;
         $display("FAIL ht_packet: lat=%0d body=%h hd=%b expected 1 %h %b", lat, b, hd, exp.body, exp.hd);
      end
      tests_run++;
      if (err_cnt - e0 !== 0) begin tests_failed++; $display("FAIL ht_err: got %0d expected 0", err_cnt - e0); end
      do_consume();
   endtask

   task automatic test_short_tail;
      pkt_t exp; logic [255:0] b; logic hd; int lat; int e0;
      e0 = err_cnt;
      sb.push_back('{{192'd0, PA}, 1'b1});
      send_flit(HEADER, VC0, PA, 1'b1);
      send_flit(TAIL,   VC0, PD, 1'b1);
      get_packet(b, hd, lat);
      exp = sb.pop_front();
      tests_run++;
      if (lat !== 1 || b !== exp.body || hd !== exp.hd) begin
         tests_failed++;
         $display("FAIL short_tail_packet: lat=%0d body=%h hd=%b expected 1 %h %b", lat, b, hd, exp.body, exp.hd);
      end
      tests_run++;
      if (err_cnt - e0 !== 1) begin tests_failed++; $display("FAIL short_tail_err: got %0d pulses expected 1", err_cnt - e0); end
      do_consume();
   endtask

   task automatic test_overflow;
      pkt_t exp; logic [255:0] b; logic hd; int lat; int e0;
      e0 = err_cnt;
      sb.push_back('{{PE, PC, PB, PA}, 1'b1});
      send_flit(HEADER, VC0, PA, 1'b1);
      send_flit(BODY,   VC0, PB, 1'b1);
      send_flit(BODY,   VC0, PC, 1'b1);
      send_flit(BODY,   VC0, PE, 1'b1);
      get_packet(b, hd, lat);
      exp = sb.pop_front();
      tests_run++;
      if (lat !== 1 || b !== exp.body || hd !== exp.hd) begin
         tests_failed++;
         $display("FAIL overflow_packet: lat=%0d body=%h hd=%b expected 1 %h %b", lat, b, hd, exp.body, exp.hd);
      end
      tests_run++;
      if (err_cnt - e0 !== 1) begin tests_failed++; $display("FAIL overflow_err: got %0d expected 1", err_cnt - e0); end
      do_consume();
   endtask

   task automatic test_restart;
      pkt_t exp; logic [255:0] b; logic hd; int lat; int e0;
      e0 = err_cnt;
      sb.push_back('{{192'd0, PE}, 1'b0});
      send_flit(HEADER, VC0, PA, 1'b1);
      send_flit(BODY,   VC0, PB, 1'b1);
      send_flit(HT,     VC0, PE, 1'b1);
      get_packet(b, hd, lat);
      exp = sb.pop_front();
      tests_run++;
      if (lat !== 1 || b !== exp.body || hd !== exp.hd) begin
         tests_failed++;
         $display("FAIL restart_packet: lat=%0d body=%h hd=%b expected 1 %h %b", lat, b, hd, exp.body, exp.hd);
      end
      tests_run++;
      if (err_cnt - e0 !== 1) begin tests_failed++; $display("FAIL restart_err: got %0d expected 1", err_cnt - e0); end
      do_consume();
   endtask

   task automatic test_orphans;
      pkt_t exp; logic [255:0] b; logic hd; int lat; int e0;
      e0 = err_cnt;
      send_flit(BODY, VC0, PX, 1'b1);
      send_flit(TAIL, VC0, PX, 1'b1);
      @(negedge clk);
      flit_valid      = 1'b0;
      packet_consumed = 1'b1;
      @(negedge clk);
      packet_consumed = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      tests_run++;
      if (packet_valid !== 1'b0 || err_cnt - e0 !== 2) begin
         tests_failed++;
         $display("FAIL orphan_idle: valid=%b pulses=%0d expected 0 2", packet_valid, err_cnt - e0);
      end
      sb.push_back('{{192'd0, PB}, 1'b0});
      send_flit(HT, VC0, PB, 1'b1);
      get_packet(b, hd, lat);
      exp = sb.pop_front();
      tests_run++;
      if (lat !== 1 || b !== exp.body || hd !== exp.hd) begin
         tests_failed++;
         $display("FAIL orphan_recover: lat=%0d body=%h hd=%b expected 1 %h %b", lat, b, hd, exp.body, exp.hd);
      end
      do_consume();
   endtask

   task automatic test_filtered;
      pkt_t exp; logic [255:0] b; logic hd; int lat; int e0;
      e0 = err_cnt;
      sb.push_back('{{PD, PC, PB, PA}, 1'b1});
      send_flit(HEADER, VC0, PA, 1'b1);
      send_flit(BODY,   VC1, PX, 1'b1);
      send_flit(BODY,   VC0, PB, 1'b1);
      send_flit(TAIL,   VC0, PX, 1'b0);
      send_flit(BODY,   VC0, PC, 1'b1);
      send_flit(HEADER, VC3, PX, 1'b1);
      send_flit(TAIL,   VC2, PX, 1'b1);
      send_flit(TAIL,   VC0, PD, 1'b1);
      get_packet(b, hd, lat);
      exp = sb.pop_front();
      tests_run++;
      if (lat !== 1 || b !== exp.body || hd !== exp.hd) begin
         tests_failed++;
         $display("FAIL filtered_packet: lat=%0d body=%h hd=%b expected 1 %h %b", lat, b, hd, exp.body, exp.hd);
      end
      tests_run++;
      if (err_cnt - e0 !== 0) begin tests_failed++; $display("FAIL filtered_err: got %0d expected 0", err_cnt - e0); end
      do_consume();
   endtask

   task automatic test_reset_midpacket;
      pkt_t exp; logic [255:0] b; logic hd; int lat; int e0;
      e0 = err_cnt;
      send_flit(HEADER, VC0, PA, 1'b1);
      send_flit(BODY,   VC0, PB, 1'b1);
      @(negedge clk);
      flit_valid = 1'b0;
      reset      = 1'b0;
      #1;
      tests_run++;
      if (packet_valid !== 1'b0 || flit_ready !== 1'b1 || packet_body !== 256'd0) begin
         tests_failed++;
         $display("FAIL midreset_state: valid=%b ready=%b body=%h expected 0 1 0", packet_valid, flit_ready, packet_body);
      end
      @(negedge clk);
      reset = 1'b1;
      sb.push_back('{{192'd0, PC}, 1'b0});
      send_flit(HT, VC0, PC, 1'b1);
      get_packet(b, hd, lat);
      exp = sb.pop_front();
      tests_run++;
      if (lat !== 1 || b !== exp.body || hd !== exp.hd) begin
         tests_failed++;
         $display("FAIL midreset_packet: lat=%0d body=%h hd=%b expected 1 %h %b", lat, b, hd, exp.body, exp.hd);
      end
      tests_run++;
      if (err_cnt - e0 !== 0) begin tests_failed++; $display("FAIL midreset_err: got %0d expected 0", err_cnt - e0); end
      do_consume();
   endtask

   task automatic test_back_to_back;
      pkt_t exp; logic [255:0] b; logic hd; int lat; int e0;
      sb.push_back('{{192'd0, PE}, 1'b0});
      send_flit(HT, VC0, PE, 1'b1);
      get_packet(b, hd, lat);
      exp = sb.pop_front();
      tests_run++;
      if (b !== exp.body || hd !== exp.hd) begin
         tests_failed++;
         $display("FAIL b2b_first: body=%h hd=%b expected %h %b", b, hd, exp.body, exp.hd);
      end
      e0 = err_cnt;
      sb.push_back('{{PD, PC, PB, PA}, 1'b1});
      @(negedge clk);
      packet_consumed = 1'b1;
      flit_valid      = 1'b1;
      flit_in_header  = '{flit_type: HEADER, vc_id: VC0};
      flit_in_payload = PA;
      tests_run++;
      if (flit_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_ready_busy: got %b expected 0", flit_ready); end
      @(negedge clk);
      packet_consumed = 1'b0;
      tests_run++;
      if (flit_ready !== 1'b1 || packet_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_ready_idle: ready=%b valid=%b expected 1 0", flit_ready, packet_valid);
      end
      send_flit(BODY, VC0, PB, 1'b1);
      send_flit(BODY, VC0, PC, 1'b1);
      send_flit(TAIL, VC0, PD, 1'b1);
      get_packet(b, hd, lat);
      exp = sb.pop_front();
      tests_run++;
      if (lat !== 1 || b !== exp.body || hd !== exp.hd) begin
         tests_failed++;
         $display("FAIL b2b_second: lat=%0d body=%h hd=%b expected 1 %h %b", lat, b, hd, exp.body, exp.hd);
      end
      tests_run++;
      if (err_cnt - e0 !== 0) begin tests_failed++; $display("FAIL b2b_err: got %0d expected 0", err_cnt - e0); end
      do_consume();
   endtask

   initial begin
      test_reset();
      test_full_packet();
      test_ht();
      test_short_tail();
      test_overflow();
      test_restart();
      test_orphans();
      test_filtered();
      test_reset_midpacket();
      test_back_to_back();
      tests_run++;
      if (sb.size() !== 0) begin
         tests_failed++;
         $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/flit_to_packet_assembler.md
FLIT_TO_PACKET_ASSEMBLER -- requirements
Module: flit_to_packet_assembler

Interface
REQ-001 SHALL have parameter VCID, default VC0: the only virtual channel this instance accepts.
REQ-002 SHALL have parameter PACKET_BODY_SIZE, default 256: the reassembled body width in bits.
REQ-003 SHALL derive localparam FLIT_NUMB = ceil(PACKET_BODY_SIZE / `PAYLOAD_W`) and COUNTER_WIDTH = $clog2(PACKET_BODY_SIZE).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port enable, input, 1 bit: when low, no flit is accepted.
REQ-007 SHALL have port flit_valid, input, 1 bit: a flit is offered by the router local port.
REQ-008 SHALL have port flit_in_header, input, flit_header_t: the offered flit's header.
REQ-009 SHALL have port flit_in_payload, input, `PAYLOAD_W` bits: the offered flit's payload chunk.
REQ-010 SHALL have port flit_ready, output, 1 bit: on/off back-pressure to the router.
REQ-011 SHALL have port packet_valid, output, 1 bit: a complete packet is held.
REQ-012 SHALL have port packet_body, output, PACKET_BODY_SIZE bits: the reassembled body.
REQ-013 SHALL have port packet_has_data, output, 1 bit: set when the packet arrived as HEADER..TAIL; clear when it arrived as HT.
REQ-014 SHALL have port packet_consumed, input, 1 bit: the consumer takes the held packet.
REQ-015 SHALL have port protocol_error, output, 1 bit: a one-cycle pulse on a framing violation.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, COLLECT, READY.
REQ-017 SHALL define flit accept as flit_valid & flit_ready & enable & (flit_in_header.vc_id == VCID).
REQ-018 SHALL drive flit_ready combinationally high in IDLE and COLLECT, and low in READY.
REQ-019 SHALL drive packet_valid high exactly while in READY; body and has_data SHALL be stable throughout READY.
REQ-020 SHALL handle an accepted flit in IDLE as follows:
- HT: store payload in chunk 0, clear remaining chunks, has_data <= 0, go to READY.
- HEADER: store payload in chunk 0, count <= 1, has_data <= 1, go to COLLECT.
- BODY or TAIL: drop the flit, pulse protocol_error, stay in IDLE.
REQ-021 SHALL handle an accepted flit in COLLECT as follows:
- BODY: store payload in chunk[count], then count+1.
- TAIL: store payload in chunk[count], go to READY.
REQ-022 SHALL pulse protocol_error and go to READY, without storing, when a TAIL arrives with count != FLIT_NUMB-1. Chunks not yet written SHALL read as zero.
REQ-023 SHALL pulse protocol_error and go to READY when a BODY arrives with count == FLIT_NUMB-1. That flit's payload SHALL be stored as the last chunk.
REQ-024 SHALL handle HEADER or HT in COLLECT as a restart: pulse protocol_error, discard the partial packet, and process the flit as in IDLE.
REQ-025 SHALL go from READY to IDLE on the cycle after packet_consumed. packet_consumed outside READY SHALL be ignored.
REQ-026 SHALL clear chunk storage and count when entering IDLE from READY.
REQ-027 SHALL ignore, without error, any flit offered while flit_ready is low or with a mismatched vc_id.
REQ-028 SHALL take packet_body from the low PACKET_BODY_SIZE bits of the FLIT_NUMB*`PAYLOAD_W` register, with chunk i at bits [i*`PAYLOAD_W` +: `PAYLOAD_W`].
REQ-029 SHALL have a latency of one cycle, from accept of the last flit to packet_valid high.
REQ-030 SHALL, when enable is low in COLLECT, hold state and count.

Reset
REQ-031 SHALL, while reset is low, force: state IDLE, count 0, body 0, has_data 0, packet_valid 0, protocol_error 0.
REQ-032 SHALL let flit_ready follow the IDLE value (high when enable-gated accept applies) during reset.
REQ-033 SHALL lose any partial or held packet on reset, with no error pulse.

Structure
REQ-034 SHALL take flit_header_t, flit_type_t (HEADER/BODY/TAIL/HT), vc_id_t and `PAYLOAD_W` from the shared network defines package. No new shared typedefs SHALL be added.
REQ-035 SHALL keep the state enum local to the module.
REQ-036 SHALL be a single module with no sub-modules.

Verification
Bench configuration: `PAYLOAD_W`=64, PACKET_BODY_SIZE=256 (FLIT_NUMB=4).
REQ-037 SHALL cover: HEADER A, BODY B, BODY C, TAIL D on consecutive cycles -> packet_valid rises the cycle after D, body={D,C,B,A}, has_data=1, flit_ready=0 until packet_consumed.
REQ-038 SHALL cover: HT with payload 0x1234 -> next cycle packet_valid=1, body=0x1234 zero-extended, has_data=0.
REQ-039 SHALL cover: HEADER then TAIL with count=1 -> protocol_error pulses once, packet_valid=1, chunks 1..3 = 0.
REQ-040 SHALL cover: flits with vc_id != VCID interleaved, and flit_valid with enable=0 -> ignored, no error, result identical to REQ-037.
REQ-041 SHALL cover: HEADER, BODY, then reset low for 1 cycle, then HT -> no error pulse, packet_valid holds the HT packet only.
REQ-042 SHALL cover: packet_consumed with a new HEADER offered the same cycle -> HEADER not accepted (flit_ready=0); accepted the next cycle in IDLE.
